spmv_mc_bridge: RTL

- Sits between the spmv_pe memory port and one Convey memory-controller (MC) port.
- Queues PE load/store requests and enforces an outstanding-load credit limit toward the MC.
- Buffers MC load responses in a FIFO so the PE's rsp_mem_stall is always honoured, and consumes store-complete responses.
- Reports idle when nothing is in flight, so the PE can gate busy_out.

---
 rtl/spmv_mem_pkg.sv | 14 +
 rtl/spmv_sync_fifo.sv | 37 +++
 rtl/spmv_mc_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/spmv_mem_pkg.sv
// spmv_mem_pkg: shared memory-port widths and request-entry layout for the PE/MC bridge
package spmv_mem_pkg;
   localparam int MEM_ADDR_W   = 48;
   localparam int TAG_W        = 3;
   localparam int RDCTL_W      = 32;
   localparam int RDCTL_ST_BIT = 31;
   localparam int DATA_W       = 64;
   // request entry is {is_st, addr, d_or_tag}
   localparam int REQ_D_LSB    = 0;
   localparam int REQ_ADDR_LSB = REQ_D_LSB + DATA_W;
   localparam int REQ_ST_BIT   = REQ_ADDR_LSB + MEM_ADDR_W;
   localparam int REQ_W        = REQ_ST_BIT + 1;
   localparam int RSP_W        = TAG_W + DATA_W;
endpackage

// File: rtl/spmv_sync_fifo.sv
// spmv_sync_fifo: single-clock show-ahead FIFO; DEPTH must be a power of 2
module spmv_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/spmv_mc_bridge.sv
// spmv_mc_bridge: PE memory port to Convey MC port with load credits and response buffering
module spmv_mc_bridge
   import spmv_mem_pkg::*;
#(
   parameter int REQ_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 32,
   parameter int RSP_DEPTH       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_mem_ld,
   input  logic                  req_mem_st,
   input  logic [MEM_ADDR_W-1:0] req_mem_addr,
   input  logic [DATA_W-1:0]     req_mem_d_or_tag,
   output logic                  req_mem_stall,
   output logic                  rsp_mem_push,
   output logic [TAG_W-1:0]      rsp_mem_tag,
   output logic [DATA_W-1:0]     rsp_mem_q,
   input  logic                  rsp_mem_stall,
   output logic                  mc_req_ld,
   output logic                  mc_req_st,
   output logic [MEM_ADDR_W-1:0] mc_req_vadr,
   output logic [DATA_W-1:0]     mc_req_wrd_rdctl,
   input  logic                  mc_req_stall,
   input  logic                  mc_rsp_push,
   input  logic [RDCTL_W-1:0]    mc_rsp_rdctl,
   input  logic [DATA_W-1:0]     mc_rsp_data,
   output logic                  mc_rsp_stall,
   output logic                  idle,
   output logic                  err
);
   localparam int LW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int QW = $clog2(REQ_DEPTH) + 1;
   localparam int RW = $clog2(RSP_DEPTH) + 1;
   localparam int SW = 16;
   if (RSP_DEPTH < MAX_OUTSTANDING) begin : g_depth_chk
      $error("spmv_mc_bridge: RSP_DEPTH must be >= MAX_OUTSTANDING");
   end
   logic [REQ_W-1:0] rq_din, rq_head;
   logic [QW-1:0] rq_count;
   logic rq_full, rq_empty, enq, issue, head_st, ld_issue, st_issue;
   logic [RSP_W-1:0] rsp_head;
   logic [RW-1:0] rsp_count;
   logic rsp_full, rsp_empty, rsp_wr, rsp_rd, st_cmpl, ld_rsp, orphan;
   logic [LW-1:0] ld_out;
   logic [SW-1:0] st_out;
   logic unused_rdctl;
   assign unused_rdctl = ^mc_rsp_rdctl[RDCTL_ST_BIT-1:TAG_W];
   assign enq      = req_mem_ld || req_mem_st;
   assign rq_din   = {req_mem_st, req_mem_addr, req_mem_d_or_tag};
   assign head_st  = rq_head[REQ_ST_BIT];
   assign issue    = !rq_empty && !mc_req_stall && (head_st || ld_out < LW'(MAX_OUTSTANDING));
   assign ld_issue = issue && !head_st;
   assign st_issue = issue && head_st;
   assign st_cmpl  = mc_rsp_push && mc_rsp_rdctl[RDCTL_ST_BIT];
   assign ld_rsp   = mc_rsp_push && !mc_rsp_rdctl[RDCTL_ST_BIT];
   // a load response with no issued-but-unreturned load behind it (e.g. after reset)
   assign orphan   = ld_rsp && (ld_out == LW'(rsp_count));
   assign rsp_wr   = ld_rsp && !orphan && !rsp_full;
   assign rsp_rd   = !rsp_empty && !rsp_mem_stall;
   assign mc_rsp_stall = 1'b0;
   spmv_sync_fifo #(.W(REQ_W), .DEPTH(REQ_DEPTH)) u_req_q (
      .clk(clk), .rst(rst), .push(enq), .pop(issue), .din(rq_din), .dout(rq_head),
      .count(rq_count), .full(rq_full), .empty(rq_empty)
   );
   spmv_sync_fifo #(.W(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_q (
      .clk(clk), .rst(rst), .push(rsp_wr), .pop(rsp_rd),
      .din({mc_rsp_rdctl[TAG_W-1:0], mc_rsp_data}), .dout(rsp_head),
      .count(rsp_count), .full(rsp_full), .empty(rsp_empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         req_mem_stall    <= 1'b0;
         mc_req_ld        <= 1'b0;
         mc_req_st        <= 1'b0;
         mc_req_vadr      <= '0;
         mc_req_wrd_rdctl <= '0;
         rsp_mem_push     <= 1'b0;
         rsp_mem_tag      <= '0;
         rsp_mem_q        <= '0;
         ld_out           <= '0;
         st_out           <= '0;
         idle             <= 1'b1;
         err              <= 1'b0;
      end else begin
         req_mem_stall    <= rq_count >= QW'(REQ_DEPTH - 2);
         mc_req_ld        <= ld_issue;
         mc_req_st        <= st_issue;
         mc_req_vadr      <= issue ? rq_head[REQ_ADDR_LSB +: MEM_ADDR_W] : '0;
         mc_req_wrd_rdctl <= st_issue ? rq_head[REQ_D_LSB +: DATA_W] :
                             ld_issue ? DATA_W'(rq_head[REQ_D_LSB +: TAG_W]) : '0;
         rsp_mem_push     <= rsp_rd;
         rsp_mem_tag      <= rsp_rd ? rsp_head[DATA_W +: TAG_W] : '0;
         rsp_mem_q        <= rsp_rd ? rsp_head[DATA_W-1:0] : '0;
         ld_out           <= ld_out + LW'(ld_issue) - LW'(rsp_mem_push);
         st_out           <= st_out + SW'(st_issue) - SW'(st_cmpl && st_out != '0);
         idle             <= rq_count == '0 && ld_out == '0 && st_out == '0 && rsp_count == '0 &&
                             !mc_req_ld && !mc_req_st;
         err              <= err || (req_mem_ld && req_mem_st) || (enq && rq_full) ||
                             (st_cmpl && st_out == '0) || orphan;
      end
   end
endmodule
